pmp_scan_checker: RTL and testbench

Sequential PMP permission checker for the CVA6 PMP path. It accepts one physical-address access request at a time and scans the PMP entries in index order, one entry per cycle, through a single `pmp_entry` comparator instance. The lowest-index matching entry decides the outcome, and the checker returns allow/deny through a valid/ready response. It sits between the CSR-held PMP configuration and the MMU/LSU fault logic, trading latency for area against a fully parallel NR_ENTRIES-comparator checker.

---
 rtl/pmp_scan_checker.sv | 190 +++++++++++++++++++
 tb/tb_pmp_scan_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_scan_checker.sv
// Sequential PMP checker: one pmp_entry comparator scanned over all entries,
// lowest-index match wins, allow/deny returned through a valid/ready response.

// Single PMP entry address matcher (OFF / TOR / NA4 / NAPOT).
// Latency: combinational.
// Backpressure: none.
module pmp_entry #(
  parameter int PLEN    = 34,
  parameter int PMP_LEN = 32
) (
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  logic [1:0]         conf_addr_mode_i,
  output logic               match_o
);
  logic [PLEN-1:0] cur_base;
  logic [PLEN-1:0] prev_base;
  logic [PLEN-1:0] napot_mask;
  logic [5:0]      ones;
  logic            ones_done;

  assign cur_base  = {conf_addr_i, 2'b00};
  assign prev_base = {conf_addr_prev_i, 2'b00};

  // Trailing ones of pmpaddr encode the NAPOT size: 2^(ones+3) bytes.
  always_comb begin
    ones      = '0;
    ones_done = 1'b0;
    for (int i = 0; i < PMP_LEN; i++) begin
      if (!ones_done && conf_addr_i[i]) ones = ones + 6'd1;
      else ones_done = 1'b1;
    end
    for (int i = 0; i < PLEN; i++) napot_mask[i] = (i >= int'(ones) + 3);
  end

  always_comb begin
    match_o = 1'b0;
    case (conf_addr_mode_i)
      2'b01:   match_o = (addr_i >= prev_base) && (addr_i < cur_base);
      2'b10:   match_o = (addr_i[PLEN-1:2] == conf_addr_i);
      2'b11:   match_o = ((addr_i ^ cur_base) & napot_mask) == '0;
      default: match_o = 1'b0;
    endcase
  end
endmodule

// PMP permission checker scanning one entry per cycle.
// Latency: k+1 cycles for first match at entry k, NR_ENTRIES cycles on a miss.
// Backpressure: response held stable while resp_ready_i is low; no new request until then.
module pmp_scan_checker #(
  parameter int NR_ENTRIES = 16,
  parameter int PLEN       = 34
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PLEN-1:0]         req_addr_i,
  input  logic [2:0]              req_type_i,
  input  logic [1:0]              req_priv_i,
  input  logic [NR_ENTRIES*32-1:0] conf_addr_i,
  input  logic [NR_ENTRIES*8-1:0] conf_i,
  output logic                    busy_o,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    resp_allow_o,
  output logic                    resp_hit_o,
  output logic [5:0]              resp_entry_o
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NR_ENTRIES - 1);

  state_t          state_q, state_d;
  logic [PLEN-1:0] addr_q;
  logic [2:0]      type_q;
  logic [1:0]      priv_q;
  logic [5:0]      idx_q;
  logic [5:0]      idx_prev;
  logic            resp_allow_q, resp_hit_q;
  logic [5:0]      resp_entry_q;

  logic [31:0]     addr_arr [64];
  logic [7:0]      cfg_arr  [64];
  logic [31:0]     cur_addr, prev_addr;
  logic [7:0]      cfg_cur;
  logic [1:0]      unused_rsvd;
  logic            match, allow_hit;

  // Pad to 64 slots so the 6-bit scan index selects without width games.
  for (genvar i = 0; i < 64; i++) begin : g_unpack
    if (i < NR_ENTRIES) begin : g_live
      assign addr_arr[i] = conf_addr_i[i*32 +: 32];
      assign cfg_arr[i]  = conf_i[i*8 +: 8];
    end else begin : g_pad
      assign addr_arr[i] = '0;
      assign cfg_arr[i]  = '0;
    end
  end

  assign idx_prev    = idx_q - 6'd1;
  assign cur_addr    = addr_arr[idx_q];
  assign prev_addr   = (idx_q == 6'd0) ? 32'd0 : addr_arr[idx_prev];
  assign cfg_cur     = cfg_arr[idx_q];
  assign unused_rsvd = cfg_cur[6:5];

  pmp_entry #(
    .PLEN    (PLEN),
    .PMP_LEN (32)
  ) u_entry (
    .addr_i           (addr_q),
    .conf_addr_i      (cur_addr),
    .conf_addr_prev_i (prev_addr),
    .conf_addr_mode_i (cfg_cur[4:3]),
    .match_o          (match)
  );

  // Unlocked entries do not constrain M-mode.
  assign allow_hit = ((priv_q == 2'b11) && !cfg_cur[7]) ? 1'b1
                   : ((type_q & cfg_cur[2:0]) == type_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    busy_o       = 1'b1;
    resp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_d = SCAN;
      end
      SCAN: begin
        if (match || (idx_q == LAST_IDX)) state_d = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q       <= '0;
      type_q       <= '0;
      priv_q       <= '0;
      idx_q        <= '0;
      resp_allow_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_entry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q <= req_addr_i;
            type_q <= req_type_i;
            priv_q <= req_priv_i;
            idx_q  <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            resp_hit_q   <= 1'b1;
            resp_entry_q <= idx_q;
            resp_allow_q <= allow_hit;
          end else if (idx_q == LAST_IDX) begin
            resp_hit_q   <= 1'b0;
            resp_entry_q <= '0;
            resp_allow_q <= (priv_q == 2'b11);
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_allow_o = resp_allow_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_entry_o = resp_entry_q;
endmodule

// File: tb/tb_pmp_scan_checker.sv
// Bench for pmp_scan_checker: directed vector table, stall/reset sequences,
// and random configurations checked against an arithmetic PMP model.
module tb_pmp_scan_checker;
  localparam int N = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [33:0]     req_addr = '0;
  logic [2:0]      req_type = '0;
  logic [1:0]      req_priv = '0;
  logic [N*32-1:0] conf_addr = '0;
  logic [N*8-1:0]  conf = '0;
  logic            busy, resp_valid, resp_allow, resp_hit;
  logic            resp_ready = 1'b0;
  logic [5:0]      resp_entry;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pmp_scan_checker #(.NR_ENTRIES(N), .PLEN(34)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_type_i   (req_type),
    .req_priv_i   (req_priv),
    .conf_addr_i  (conf_addr),
    .conf_i       (conf),
    .busy_o       (busy),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_allow_o (resp_allow),
    .resp_hit_o   (resp_hit),
    .resp_entry_o (resp_entry)
  );

  typedef struct {
    int          i0;
    logic [31:0] a0;
    logic [7:0]  c0;
    int          i1;
    logic [31:0] a1;
    logic [7:0]  c1;
    logic [33:0] addr;
    logic [2:0]  typ;
    logic [1:0]  priv;
    logic        allow;
    logic        hit;
    int          ent;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] a, input logic [7:0] c);
    conf_addr[i*32 +: 32] = a;
    conf[i*8 +: 8]        = c;
  endtask

  // Reference: walk entries in order using plain integer range arithmetic.
  function automatic void model(input logic [33:0] addr, input logic [2:0] typ,
                                input logic [1:0] priv, output logic allow,
                                output logic hit, output int ent);
    longint a;
    a     = longint'(addr);
    hit   = 1'b0;
    ent   = 0;
    allow = (priv == 2'd3);
    for (int i = 0; i < N; i++) begin
      longint cur, prev, t, size, base;
      int     mode;
      bit     m;
      cur  = longint'(conf_addr[i*32 +: 32]);
      prev = (i == 0) ? 64'd0 : longint'(conf_addr[(i-1)*32 +: 32]);
      mode = int'(conf[i*8+3 +: 2]);
      m    = 1'b0;
      case (mode)
        1: m = (a >= prev * 4) && (a < cur * 4);
        2: m = (a / 4 == cur);
        3: begin
          t    = cur;
          size = 8;
          while (t % 2 == 1) begin
            t    = t / 2;
            size = size * 2;
          end
          base = ((cur * 4) / size) * size;
          m    = (a >= base) && (a < base + size);
        end
        default: m = 1'b0;
      endcase
      if (m) begin
        hit = 1'b1;
        ent = i;
        if (priv == 2'd3 && !conf[i*8+7]) allow = 1'b1;
        else allow = ((typ & conf[i*8 +: 3]) == typ);
        break;
      end
    end
  endfunction

  task automatic run_req(input string name, input logic [33:0] addr, input logic [2:0] typ,
                         input logic [1:0] priv, input logic ea, input logic eh,
                         input int ee, input int el, input int stall);
    int lat;
    @(negedge clk);
    req_addr  = addr;
    req_type  = typ;
    req_priv  = priv;
    req_valid = 1'b1;
    chk({name, ".req_ready"}, int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, ".busy"}, int'(busy), 1);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, lat, el);
    chk({name, ".allow"}, int'(resp_allow), int'(ea));
    chk({name, ".hit"}, int'(resp_hit), int'(eh));
    chk({name, ".entry"}, int'(resp_entry), ee);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({name, ".stall_valid"}, int'(resp_valid), 1);
      chk({name, ".stall_allow"}, int'(resp_allow), int'(ea));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, ".idle_after"}, int'(resp_valid), 0);
  endtask

  initial begin
    logic ea, eh;
    int   ee, seen;

    vecs[0]  = '{0, 32'h2000_01FF, 8'h19, 0, 32'h2000_01FF, 8'h19, 34'h0_8000_0ABC, 3'b001, 2'd0, 1'b1, 1'b1, 0, 1};
    vecs[1]  = '{0, 32'h2000_01FF, 8'h19, 0, 32'h2000_01FF, 8'h19, 34'h0_8000_0ABC, 3'b010, 2'd0, 1'b0, 1'b1, 0, 1};
    vecs[2]  = '{0, 32'h2000_01FF, 8'h19, 0, 32'h2000_01FF, 8'h19, 34'h0_8000_1000, 3'b001, 2'd0, 1'b0, 1'b0, 0, N};
    vecs[3]  = '{0, 32'h2000_01FF, 8'h19, 0, 32'h2000_01FF, 8'h19, 34'h0_7FFF_FFFC, 3'b001, 2'd0, 1'b0, 1'b0, 0, N};
    vecs[4]  = '{0, 32'h0400_0000, 8'h00, 1, 32'h0400_0400, 8'h0F, 34'h0_1000_0FFC, 3'b100, 2'd1, 1'b1, 1'b1, 1, 2};
    vecs[5]  = '{0, 32'h0400_0000, 8'h00, 1, 32'h0400_0400, 8'h0F, 34'h0_1000_1000, 3'b100, 2'd1, 1'b0, 1'b0, 0, N};
    vecs[6]  = '{0, 32'h0400_0000, 8'h00, 1, 32'h0400_0400, 8'h0F, 34'h0_1000_0000, 3'b100, 2'd1, 1'b1, 1'b1, 1, 2};
    vecs[7]  = '{0, 32'h0000_0000, 8'h00, 0, 32'h0000_0000, 8'h00, 34'h0_0000_0000, 3'b001, 2'd3, 1'b1, 1'b0, 0, N};
    vecs[8]  = '{0, 32'h0000_0000, 8'h00, 0, 32'h0000_0000, 8'h00, 34'h0_0000_0000, 3'b001, 2'd0, 1'b0, 1'b0, 0, N};
    vecs[9]  = '{3, 32'h0000_0100, 8'h91, 3, 32'h0000_0100, 8'h91, 34'h0_0000_0400, 3'b010, 2'd3, 1'b0, 1'b1, 3, 4};
    vecs[10] = '{3, 32'h0000_0100, 8'h11, 3, 32'h0000_0100, 8'h11, 34'h0_0000_0400, 3'b010, 2'd3, 1'b1, 1'b1, 3, 4};
    vecs[11] = '{3, 32'h0000_0100, 8'h91, 3, 32'h0000_0100, 8'h91, 34'h0_0000_0400, 3'b001, 2'd3, 1'b1, 1'b1, 3, 4};
    vecs[12] = '{3, 32'h0000_0100, 8'h91, 3, 32'h0000_0100, 8'h91, 34'h0_0000_0404, 3'b010, 2'd3, 1'b1, 1'b0, 0, N};
    vecs[13] = '{2, 32'h2000_01FF, 8'h19, 5, 32'h2000_01FF, 8'h1F, 34'h0_8000_0004, 3'b010, 2'd0, 1'b0, 1'b1, 2, 3};
    vecs[14] = '{0, 32'h0000_0100, 8'h0B, 0, 32'h0000_0100, 8'h0B, 34'h0_0000_03FC, 3'b010, 2'd0, 1'b1, 1'b1, 0, 1};
    vecs[15] = '{0, 32'h0400_0400, 8'h00, 1, 32'h0400_0000, 8'h0F, 34'h0_1000_0000, 3'b100, 2'd1, 1'b0, 1'b0, 0, N};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.req_ready", int'(req_ready), 1);
    chk("rst.busy", int'(busy), 0);
    chk("rst.resp_valid", int'(resp_valid), 0);
    chk("rst.allow", int'(resp_allow), 0);
    chk("rst.hit", int'(resp_hit), 0);
    chk("rst.entry", int'(resp_entry), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      conf_addr = '0;
      conf      = '0;
      set_entry(vecs[v].i0, vecs[v].a0, vecs[v].c0);
      set_entry(vecs[v].i1, vecs[v].a1, vecs[v].c1);
      run_req($sformatf("vec%0d", v), vecs[v].addr, vecs[v].typ, vecs[v].priv,
              vecs[v].allow, vecs[v].hit, vecs[v].ent, vecs[v].lat, v % 3);
    end

    // Response held under backpressure; queued request accepted one cycle after handshake
    conf_addr = '0;
    conf      = '0;
    set_entry(0, 32'h2000_01FF, 8'h19);
    @(negedge clk);
    req_addr  = 34'h0_8000_0ABC;
    req_type  = 3'b001;
    req_priv  = 2'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_type  = 3'b010;
    @(negedge clk);
    chk("hold.resp_valid", int'(resp_valid), 1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("hold.valid", int'(resp_valid), 1);
      chk("hold.allow", int'(resp_allow), 1);
      chk("hold.hit", int'(resp_hit), 1);
      chk("hold.entry", int'(resp_entry), 0);
      chk("hold.req_ready", int'(req_ready), 0);
      chk("hold.busy", int'(busy), 1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold.idle_ready", int'(req_ready), 1);
    chk("hold.idle_valid", int'(resp_valid), 0);
    chk("hold.idle_busy", int'(busy), 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold.next_accepted", int'(busy), 1);
    @(negedge clk);
    chk("hold.next_valid", int'(resp_valid), 1);
    chk("hold.next_allow", int'(resp_allow), 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Random configurations against the model
    for (int r = 0; r < 40; r++) begin
      logic [33:0] ra;
      logic [2:0]  rt;
      logic [1:0]  rp;
      int          p;
      for (int i = 0; i < N; i++) begin
        int          mode, t;
        logic [31:0] a;
        logic [7:0]  c;
        mode = int'($urandom_range(0, 3));
        if (mode == 3) begin
          t = int'($urandom_range(0, 5));
          a = ($urandom_range(0, 15) << (t + 1)) | ((32'd1 << t) - 32'd1);
        end else begin
          a = $urandom_range(0, 32'h100);
        end
        c = {1'($urandom_range(0, 1)), 2'b00, 2'(mode), 3'($urandom_range(0, 7))};
        set_entry(i, a, c);
      end
      ra = 34'($urandom_range(0, 32'h4FF));
      rt = 3'b001 << $urandom_range(0, 2);
      p  = int'($urandom_range(0, 2));
      rp = (p == 2) ? 2'd3 : 2'(p);
      model(ra, rt, rp, ea, eh, ee);
      run_req($sformatf("rand%0d", r), ra, rt, rp, ea, eh, ee, eh ? ee + 1 : N,
              int'($urandom_range(0, 2)));
    end

    // Synchronous reset in the middle of a scan discards the request
    conf_addr = '0;
    conf      = '0;
    @(negedge clk);
    req_addr  = 34'h0;
    req_type  = 3'b001;
    req_priv  = 2'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.req_ready", int'(req_ready), 1);
    chk("midrst.resp_valid", int'(resp_valid), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.hit", int'(resp_hit), 0);
    seen = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("midrst.no_response", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
